// File: rtl/fpu_pkg.sv
// Shared types, widths and operand classifiers for the sequential
// single-precision multiplier.
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int PROD_W = 48;
  localparam logic [31:0] QNAN = 32'h7FC00000;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
  endfunction

  // Zero exponent counts as zero: denormal inputs are flushed.
  function automatic logic is_zero(input logic [31:0] x);
    return (x[30:23] == 8'h00);
  endfunction

endpackage

// File: rtl/fpu_mul_norm.sv
// Combinational normalize/round/exponent stage: turns the 48-bit mantissa
// product plus the operand classification into a packed result and flags.
module fpu_mul_norm
  import fpu_pkg::*;
#(
  parameter int BIAS = 127
) (
  input  logic [PROD_W-1:0] i_prod,
  input  logic [EXP_W-1:0]  i_ea,
  input  logic [EXP_W-1:0]  i_eb,
  input  logic              i_sa,
  input  logic              i_sb,
  input  logic              i_any_nan,
  input  logic              i_inf_x_zero,
  input  logic              i_any_inf,
  input  logic              i_any_zero,
  output logic [31:0]       o_result,
  output logic              o_ovf,
  output logic              o_unf,
  output logic              o_inv
);

  logic              w_sign;
  logic [FRAC_W-1:0] w_frac_raw;
  logic              w_rnd;
  logic [1:0]        w_adj;
  logic [FRAC_W:0]   w_frac_sum;
  logic [1:0]        w_adj_rnd;
  logic [FRAC_W-1:0] w_frac;
  logic signed [9:0] w_exp;

  assign w_sign     = i_sa ^ i_sb;
  assign w_frac_raw = i_prod[47] ? i_prod[46:24] : i_prod[45:23];
  assign w_rnd      = i_prod[47] ? i_prod[23] : i_prod[22];
  assign w_adj      = i_prod[47] ? 2'd1 : 2'd0;

  // Half-up rounding; a carry out of the fraction bumps the exponent.
  assign w_frac_sum = {1'b0, w_frac_raw} + {{FRAC_W{1'b0}}, w_rnd};
  assign w_adj_rnd  = w_adj + {1'b0, w_frac_sum[FRAC_W]};
  assign w_frac     = (i_prod == '0) ? '0 : w_frac_sum[FRAC_W-1:0];

  assign w_exp = signed'(10'({2'b00, i_ea}) + 10'({2'b00, i_eb})
                         + 10'(w_adj_rnd) - 10'(BIAS));

  always_comb begin
    o_result = '0;
    o_ovf    = 1'b0;
    o_unf    = 1'b0;
    o_inv    = 1'b0;
    if (i_any_nan || i_inf_x_zero) begin
      o_result = QNAN;
      o_inv    = 1'b1;
    end else if (i_any_inf) begin
      o_result = {w_sign, 8'hFF, 23'd0};
    end else if (i_any_zero) begin
      o_result = {w_sign, 31'd0};
    end else if (w_exp >= 10'sd255) begin
      o_result = {w_sign, 8'hFF, 23'd0};
      o_ovf    = 1'b1;
    end else if (w_exp <= 10'sd0) begin
      o_result = {w_sign, 31'd0};
      o_unf    = 1'b1;
    end else begin
      o_result = {w_sign, w_exp[7:0], w_frac};
    end
  end

endmodule

// File: rtl/fpu_mul_seq.sv
// Sequential single-precision multiplier: valid/ready operand intake, shift-add
// mantissa multiply, one normalize cycle, held result on a valid/ready output.
module fpu_mul_seq
  import fpu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1,
  parameter int BIAS           = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_ovf,
  output logic        flag_unf,
  output logic        flag_inv,
  output state_t      o_dbg_state
);

  localparam int ITER  = MANT_W / BITS_PER_CYCLE;
  localparam int CNT_W = 5;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and ready is only high in IDLE
  // (input side) while out_valid is only high in DONE (output side).

  state_t              r_state;
  state_t              w_next;
  logic [31:0]         r_a;
  logic [31:0]         r_b;
  logic [PROD_W-1:0]   r_mcand;
  logic [MANT_W-1:0]   r_mplier;
  logic [PROD_W-1:0]   r_acc;
  logic [CNT_W-1:0]    r_cnt;
  logic [31:0]         r_result;
  logic                r_ovf;
  logic                r_unf;
  logic                r_inv;

  logic [PROD_W-1:0]   w_pp;
  logic [31:0]         w_norm_result;
  logic                w_norm_ovf;
  logic                w_norm_unf;
  logic                w_norm_inv;
  logic                w_last;

  assign w_last = (r_cnt == CNT_W'(ITER - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = MUL;
      MUL:     if (w_last) w_next = NORM;
      NORM:    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The multiplicand is pre-shifted each step so the partial product lands
  // at the current bit position without a separate shift counter.
  assign w_pp = r_mcand * PROD_W'(r_mplier[BITS_PER_CYCLE-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_inv    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a      <= a;
            r_b      <= b;
            r_mcand  <= {{(PROD_W-MANT_W){1'b0}}, |a[30:23], a[22:0]};
            r_mplier <= {|b[30:23], b[22:0]};
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        MUL: begin
          r_acc    <= r_acc + w_pp;
          r_mcand  <= r_mcand << BITS_PER_CYCLE;
          r_mplier <= r_mplier >> BITS_PER_CYCLE;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
        NORM: begin
          r_result <= w_norm_result;
          r_ovf    <= w_norm_ovf;
          r_unf    <= w_norm_unf;
          r_inv    <= w_norm_inv;
        end
        default: ;
      endcase
    end
  end

  fpu_mul_norm #(
    .BIAS (BIAS)
  ) u_norm (
    .i_prod       (r_acc),
    .i_ea         (r_a[30:23]),
    .i_eb         (r_b[30:23]),
    .i_sa         (r_a[31]),
    .i_sb         (r_b[31]),
    .i_any_nan    (is_nan(r_a) || is_nan(r_b)),
    .i_inf_x_zero ((is_inf(r_a) && is_zero(r_b)) || (is_inf(r_b) && is_zero(r_a))),
    .i_any_inf    (is_inf(r_a) || is_inf(r_b)),
    .i_any_zero   (is_zero(r_a) || is_zero(r_b)),
    .o_result     (w_norm_result),
    .o_ovf        (w_norm_ovf),
    .o_unf        (w_norm_unf),
    .o_inv        (w_norm_inv)
  );

  assign in_ready    = (r_state == IDLE) && !rst;
  assign out_valid   = (r_state == DONE);
  assign result      = r_result;
  assign flag_ovf    = r_ovf;
  assign flag_unf    = r_unf;
  assign flag_inv    = r_inv;
  assign o_dbg_state = r_state;

endmodule
